// File: rtl/tt_response_checker.sv
// -----------------------------------------------------------------------------
// tt_response_checker
//
// On-chip exhaustive self-test for three-input combinational modules. Steps
// the DUT inputs {a,b,c} through vectors 0..7, holds each one for the dwell
// time, and samples the DUT output y on the last cycle of each vector. The
// samples form the observed truth table, which is checked against EXPECTED.
//
// Parameters:
//   DWELL    - cycles each vector is held (1..15)
//   EXPECTED - expected truth table, bit index = {a,b,c} (a is the MSB)
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   start    - level-sampled run request, honoured only in IDLE
//   a, b, c  - DUT stimulus (a = MSB of the vector)
//   y        - DUT response
//   busy     - high while vectors are being applied
//   done     - one-cycle pulse when a run completes
//   pass     - last completed run had no mismatches; held until next start
//   tt_out   - observed truth table (unsampled bits read 0)
//   err_cnt  - number of mismatching vectors, 0..8
//
// Build option:
//   TTCHK_YSYNC_EN - route y through a two-flop synchronizer before sampling;
//                    the effective dwell becomes max(DWELL, 3).
// -----------------------------------------------------------------------------
module tt_response_checker #(
    parameter int unsigned DWELL    = 4,
    parameter logic [7:0]  EXPECTED = 8'hE8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] tt_out,
    output logic [3:0] err_cnt
);

    logic y_smp;

`ifdef TTCHK_YSYNC_EN
    // Two synchronizer stages need at least three cycles of dwell so the
    // sampled value belongs to the vector currently being driven.
    localparam int unsigned EFF_DWELL = (DWELL < 3) ? 3 : DWELL;

    logic y_s1_q;
    logic y_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_s1_q <= 1'b0;
            y_s2_q <= 1'b0;
        end else begin
            y_s1_q <= y;
            y_s2_q <= y_s1_q;
        end
    end

    assign y_smp = y_s2_q;
`else
    localparam int unsigned EFF_DWELL = DWELL;

    assign y_smp = y;
`endif

    localparam logic [3:0] LAST_CNT = 4'(EFF_DWELL - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_DONE
    } state_e;

    state_e     state_q;
    logic [2:0] vec_q;
    logic [3:0] cnt_q;
    logic [2:0] abc_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [7:0] tt_q;
    logic [3:0] err_q;

    logic [7:0] tt_d;
    logic [3:0] err_d;

    // Table and error count as they will be after sampling the current vector.
    always_comb begin
        tt_d         = tt_q;
        tt_d[vec_q]  = y_smp;
        err_d        = err_q;
        if (y_smp != EXPECTED[vec_q]) begin
            err_d = err_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            abc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            tt_q    <= '0;
            err_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= ST_DRIVE;
                        vec_q   <= '0;
                        cnt_q   <= '0;
                        abc_q   <= '0;
                        busy_q  <= 1'b1;
                        pass_q  <= 1'b0;
                        tt_q    <= '0;
                        err_q   <= '0;
                    end
                end

                ST_DRIVE: begin
                    if (cnt_q == LAST_CNT) begin
                        tt_q  <= tt_d;
                        err_q <= err_d;
                        cnt_q <= '0;
                        if (vec_q == 3'd7) begin
                            // pass is judged on the count including vector 7.
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            pass_q  <= (err_d == 4'd0);
                            abc_q   <= '0;
                        end else begin
                            vec_q <= vec_q + 3'd1;
                            abc_q <= vec_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end

                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign a       = abc_q[2];
    assign b       = abc_q[1];
    assign c       = abc_q[0];
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign tt_out  = tt_q;
    assign err_cnt = err_q;

endmodule
